// File: rtl/sm_run_ctrl.sv
// sm_run_ctrl - run-control sequencer for the schoolMIPS core.
//
// Drives the core clock-enable so the core can be halted, free-run,
// single-stepped or run for a bounded number of cycles. It can optionally
// stop the core when the fetched PC matches a breakpoint address.
//
// Optional feature macro: SM_RUN_CTRL_BREAKPOINT_EN
//   defined   : breakpoint compare is built and bp_hit pulses on a stop
//   undefined : bp_addr / bp_valid are ignored and bp_hit is tied to 0
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   cmd_valid    command presented
//   cmd_ready    high from the first edge after reset; commands take one cycle
//   cmd_op       00 HALT, 01 RUN, 10 STEP, 11 RUN_N
//   cmd_count    RUN_N cycle count, sampled on acceptance
//   pc           core PC (word address)
//   bp_addr      breakpoint word address
//   bp_valid     breakpoint armed
//   cpu_en       registered clock-enable for sm_top.clkEnable
//   halted       high in HALT
//   state        0 HALT, 1 RUN, 2 STEP, 3 RUNN
//   cycles_left  remaining RUN_N cycles
//   bp_hit       one-cycle pulse on a breakpoint stop
//   cmd_err      one-cycle pulse when a command is dropped
module sm_run_ctrl #(
  parameter int unsigned PC_WIDTH  = 32,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [CNT_WIDTH-1:0] cmd_count,
  input  logic [PC_WIDTH-1:0]  pc,
  input  logic [PC_WIDTH-1:0]  bp_addr,
  input  logic                 bp_valid,
  output logic                 cpu_en,
  output logic                 halted,
  output logic [1:0]           state,
  output logic [CNT_WIDTH-1:0] cycles_left,
  output logic                 bp_hit,
  output logic                 cmd_err
);

  typedef enum logic [1:0] {
    S_HALT = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_RUNN = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_HALT = 2'd0,
    OP_RUN  = 2'd1,
    OP_STEP = 2'd2,
    OP_RUNN = 2'd3
  } op_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 err_d;
  logic                 bp_cond;
  logic                 accept;
  op_t                  op;

  assign accept = cmd_valid && cmd_ready;
  assign op     = op_t'(cmd_op);

`ifdef SM_RUN_CTRL_BREAKPOINT_EN
  // en_prev masks the first enabled cycle after leaving HALT, so RUN issued
  // while parked on the breakpoint address executes past it instead of
  // stopping again immediately.
  logic en_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) en_prev <= 1'b0;
    else     en_prev <= cpu_en;
  end

  assign bp_cond = bp_valid && (pc == bp_addr) && cpu_en && en_prev &&
                   ((state_q == S_RUN) || (state_q == S_RUNN));
`else
  logic unused_bp;
  assign unused_bp = ^{pc, bp_addr, bp_valid};
  assign bp_cond   = 1'b0;
`endif

  // State register; cpu_en is registered from the next state so it is
  // always the image of the state it accompanies.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_HALT;
      cnt_q     <= '0;
      cpu_en    <= 1'b0;
      bp_hit    <= 1'b0;
      cmd_err   <= 1'b0;
      cmd_ready <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cpu_en    <= (state_d != S_HALT);
      bp_hit    <= bp_cond;
      cmd_err   <= err_d;
      cmd_ready <= 1'b1;
    end
  end

  // Next state: autonomous progression first, then command overrides.
  // An accepted HALT overrides everything; breakpoint beats exhaustion
  // (both lead to HALT, bp_hit pulses regardless).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;

    unique case (state_q)
      S_HALT: ;
      S_RUN:  if (bp_cond) state_d = S_HALT;
      S_STEP: state_d = S_HALT;
      S_RUNN: begin
        cnt_d = cnt_q - 1'b1;
        if (bp_cond || (cnt_q == CNT_WIDTH'(1))) state_d = S_HALT;
      end
    endcase

    if (accept) begin
      if (op == OP_HALT) begin
        state_d = S_HALT;
      end else if (state_q != S_HALT) begin
        err_d = 1'b1;
      end else begin
        case (op)
          OP_RUN:  state_d = S_RUN;
          OP_STEP: state_d = S_STEP;
          OP_RUNN: begin
            if (cmd_count != '0) begin
              state_d = S_RUNN;
              cnt_d   = cmd_count;
            end else begin
              err_d = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end

    // Nothing is pending once halted, whichever way HALT was reached.
    if (state_d == S_HALT) cnt_d = '0;
  end

  always_comb begin
    halted      = (state_q == S_HALT);
    state       = state_q;
    cycles_left = cnt_q;
  end

endmodule

// File: doc/sm_run_ctrl.md
# sm_run_ctrl

Run-control sequencer for the schoolMIPS core. It drives the core's clock-enable to halt, free-run, single-step, or run a bounded number of cycles. It optionally stops the core when the fetched PC matches a breakpoint. It sits between a debug command source (switches, UART or bench) and the `clkEnable` input of `sm_top`, and observes the core PC (word address, as on `regData` with `regAddr = 0`).

## Interface

Parameters:
- `PC_WIDTH`, 32: width of the PC and breakpoint compare.
- `CNT_WIDTH`, 16: width of the RUN_N cycle count.

Ports:
- `clk`  in  1: system clock; all state updates on its rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `cmd_valid`  in  1: a command is presented.
- `cmd_ready`  out  1: constant 1 out of reset; every presented command is consumed in one cycle.
- `cmd_op`  in  2: command opcode: 00 HALT, 01 RUN, 10 STEP, 11 RUN_N.
- `cmd_count`  in  CNT_WIDTH: cycle count for RUN_N; sampled only on acceptance.
- `pc`  in  PC_WIDTH: current core PC, word address.
- `bp_addr`  in  PC_WIDTH: breakpoint word address.
- `bp_valid`  in  1: breakpoint armed.
- `cpu_en`  out  1: registered; connects to `sm_top.clkEnable`.
- `halted`  out  1: high in state HALT.
- `state`  out  2: 0 HALT, 1 RUN, 2 STEP, 3 RUNN.
- `cycles_left`  out  CNT_WIDTH: remaining RUN_N cycles.
- `bp_hit`  out  1: one-cycle pulse when a breakpoint stop occurs.
- `cmd_err`  out  1: one-cycle pulse when a command is dropped.

## Operation

Reset values:
- `cpu_en`=0, `halted`=1, `state`=0, `cycles_left`=0, `bp_hit`=0, `cmd_err`=0, `cmd_ready`=0.
- `cmd_ready` rises on the first clock edge after `rst` deasserts.

Command acceptance:
- A command is accepted when `cmd_valid && cmd_ready`.
- HALT is accepted in any state. It moves to HALT, and `cpu_en` is 0 on the next cycle.

Transitions from HALT:
- RUN goes to RUN.
- STEP goes to STEP.
- RUN_N with `cmd_count` N>0 goes to RUNN and loads `cycles_left` = N.
- RUN_N with N=0 stays in HALT and pulses `cmd_err`.
- HALT while already in HALT is a no-op with no error.

Dropped commands:
- RUN, STEP or RUN_N accepted while not in HALT is dropped.
- The state is unchanged and `cmd_err` pulses for one cycle.

Per-state behaviour (`cpu_en` is the registered image of the state):
- RUN: `cpu_en`=1 every cycle until HALT or a breakpoint.
- STEP: `cpu_en`=1 for exactly one cycle, then HALT automatically.
- RUNN: `cpu_en`=1 for exactly N cycles. `cycles_left` decrements once per `cpu_en` cycle; on reaching 0 the state goes to HALT. There is no wrap.

Breakpoint (see Configuration):
- The condition is `bp_valid && pc == bp_addr` on a cycle where `cpu_en`=1, in RUN or RUNN.
- On the condition, the next state is HALT and `bp_hit` pulses for one cycle.
- The instruction at `bp_addr` has executed; the core halts after it.
- STEP ignores breakpoints, so a user can step off a breakpoint.
- RUN from HALT with `pc == bp_addr` does not re-trigger, because the compare only counts cycles where `cpu_en`=1 was already set. RUN therefore resumes past the breakpoint.

Simultaneous events, in priority order:
1. `rst`.
2. Accepted HALT.
3. Breakpoint.
4. RUNN count exhaustion.

If a breakpoint coincides with HALT or with exhaustion, `bp_hit` still pulses.

## Timing

- Command accepted at edge t: `state`, `halted` and `cpu_en` reflect it after edge t, with one cycle of latency.
- STEP: `cpu_en` is high for the single cycle after acceptance and low from the following cycle.
- RUN_N, N: `cpu_en` is high for cycles t+1..t+N. `cycles_left` reads N at t+1 and 0 at t+N+1.
- Breakpoint seen in cycle c: `cpu_en`=0 and `bp_hit`=1 in cycle c+1, and `bp_hit`=0 in c+2.
- `rst` asserted mid-operation: `cpu_en` drops asynchronously, all outputs take their reset values, and the pending count is discarded.

## Configuration

- Macro: `SM_RUN_CTRL_BREAKPOINT_EN`.
- Defined: breakpoint compare and `bp_hit` behave as described above.
- Undefined: the compare logic is not built. `bp_addr` and `bp_valid` are ignored, `bp_hit` is tied to 0, and RUN continues until HALT.
- All ports exist in both builds.

## Test plan

- Reset, then wait 10 cycles: `cpu_en`=0, `halted`=1, `state`=0. After the first post-reset edge, `cmd_ready`=1.
- STEP three times, 4 cycles apart: `cpu_en` is high for exactly 3 isolated cycles and `pc` advances by 3.
- RUN_N with N=5: `cpu_en` is high for exactly 5 consecutive cycles and `cycles_left` reads 5,4,3,2,1,0. RUN_N with N=0: `cmd_err` pulses and `cpu_en` stays 0.
- With the macro defined, `bp_addr`=4, `bp_valid`=1, then RUN:
  - The core halts one cycle after `pc`=4 is seen with `cpu_en`=1, and `bp_hit` pulses once.
  - A second RUN resumes without an immediate hit.
  - With the macro undefined, the same stimulus never halts.
- In RUN: STEP is dropped with a `cmd_err` pulse. HALT coinciding with a breakpoint gives HALT plus a `bp_hit` pulse. `rst` mid-RUNN with `cycles_left`=7 drives `cpu_en` to 0 asynchronously and `cycles_left` to 0.
